// File: rtl/obj_track_queue.sv
// Sorted FIFO of track objects with per-frame scrolling and auto-retire of objects reaching the player line.
// Latency: updates land on the next rising edge; rd_obj is combinational from registered state.
// Backpressure: no stall; a push that finds no space or is out of order is dropped and flagged.
module obj_track_queue #(
  parameter int ADDR_WIDTH = 4,
  parameter int DIST_W     = 12,
  parameter int LANE_W     = 2,
  parameter int TYPE_W     = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push,
  input  logic [DIST_W+LANE_W+TYPE_W-1:0]  wr_obj,
  input  logic                             pop,
  input  logic                             scroll,
  input  logic [DIST_W-1:0]                scroll_step,
  input  logic                             clr_flags,
  input  logic [ADDR_WIDTH-1:0]            rd_index,
  output logic [DIST_W+LANE_W+TYPE_W-1:0]  rd_obj,
  output logic [ADDR_WIDTH:0]              num,
  output logic                             empty,
  output logic                             full,
  output logic                             push_ok,
  output logic                             order_err,
  output logic                             overflow,
  output logic [ADDR_WIDTH:0]              exp_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OBJ_W = DIST_W + LANE_W + TYPE_W;
  localparam logic [OBJ_W-1:0] EMPTY_OBJ = {{(TYPE_W+LANE_W){1'b0}}, {DIST_W{1'b1}}};

  logic [OBJ_W-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] front;
  logic [ADDR_WIDTH:0]   num_q;

  logic                  scroll_eff;
  logic [DIST_W-1:0]     step_eff;
  logic [ADDR_WIDTH:0]   exp_n;
  logic                  run;
  logic [ADDR_WIDTH:0]   num1;
  logic [ADDR_WIDTH-1:0] front1;
  logic                  pop_eff;
  logic [ADDR_WIDTH:0]   num2;
  logic [ADDR_WIDTH-1:0] front2;
  logic [ADDR_WIDTH-1:0] tail_idx;
  logic [DIST_W-1:0]     tail_dist;
  logic                  space_ok;
  logic                  order_ok;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_phys;

  // A zero step moves nothing, so it must not retire zero-distance entries either.
  assign scroll_eff = scroll && (scroll_step != '0);
  assign step_eff   = scroll_eff ? scroll_step : '0;

  // Count the front prefix of entries that reach the player line on this scroll.
  always_comb begin
    exp_n = '0;
    run   = scroll_eff;
    for (int i = 0; i < DEPTH; i++) begin
      if (run && ((ADDR_WIDTH+1)'(i) < num_q) &&
          (mem[front + ADDR_WIDTH'(i)][DIST_W-1:0] <= scroll_step)) begin
        exp_n = exp_n + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // Retire, then pop, then decide on the push against the post-scroll tail.
  assign num1      = num_q - exp_n;
  assign front1    = front + exp_n[ADDR_WIDTH-1:0];
  assign pop_eff   = pop && (num1 != '0);
  assign num2      = num1 - {{ADDR_WIDTH{1'b0}}, pop_eff};
  assign front2    = front1 + {{(ADDR_WIDTH-1){1'b0}}, pop_eff};
  // Tail slot is unaffected by retire/pop whenever survivors remain; otherwise unused.
  assign tail_idx  = front + num_q[ADDR_WIDTH-1:0] - 1'b1;
  assign tail_dist = mem[tail_idx][DIST_W-1:0] - step_eff;
  // num2 never exceeds DEPTH, so its MSB alone marks a full queue.
  assign space_ok  = ~num2[ADDR_WIDTH];
  assign order_ok  = (num2 == '0) || (wr_obj[DIST_W-1:0] >= tail_dist);
  assign accept    = push && space_ok && order_ok;
  assign wr_idx    = front2 + num2[ADDR_WIDTH-1:0];

  // Pointer, occupancy and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front     <= '0;
      num_q     <= '0;
      push_ok   <= 1'b0;
      order_err <= 1'b0;
      overflow  <= 1'b0;
      exp_count <= '0;
    end else begin
      front     <= front2;
      num_q     <= num2 + {{ADDR_WIDTH{1'b0}}, accept};
      push_ok   <= accept;
      order_err <= push && space_ok && !order_ok;
      exp_count <= exp_n;
      if (push && !space_ok) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage: scroll every surviving distance in parallel; the new tail write lands last.
  always_ff @(posedge clk) begin
    if (scroll_eff) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (mem[k][DIST_W-1:0] > scroll_step) begin
          mem[k][DIST_W-1:0] <= mem[k][DIST_W-1:0] - scroll_step;
        end
      end
    end
    if (accept) begin
      mem[wr_idx] <= wr_obj;
    end
  end

  assign rd_phys   = front + rd_index;
  assign rd_obj    = ({1'b0, rd_index} < num_q) ? mem[rd_phys] : EMPTY_OBJ;
  assign num       = num_q;
  assign empty     = (num_q == '0);
  assign full      = (num_q == (ADDR_WIDTH+1)'(DEPTH));

endmodule

// File: tb/tb_obj_track_queue.sv
// Bench for obj_track_queue: a queue-based reference model predicts each cycle's outputs,
// expected records go into a scoreboard when stimulus is driven and are compared after the edge,
// and the full visible contents are read back through rd_index every cycle.
module tb_obj_track_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push = 1'b0;
  logic [15:0] wr_obj = '0;
  logic        pop = 1'b0;
  logic        scroll = 1'b0;
  logic [11:0] scroll_step = '0;
  logic        clr_flags = 1'b0;
  logic [3:0]  rd_index = '0;
  logic [15:0] rd_obj;
  logic [4:0]  num;
  logic        empty;
  logic        full;
  logic        push_ok;
  logic        order_err;
  logic        overflow;
  logic [4:0]  exp_count;

  obj_track_queue #(.ADDR_WIDTH(4), .DIST_W(12), .LANE_W(2), .TYPE_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .wr_obj(wr_obj), .pop(pop),
    .scroll(scroll), .scroll_step(scroll_step), .clr_flags(clr_flags),
    .rd_index(rd_index), .rd_obj(rd_obj), .num(num), .empty(empty), .full(full),
    .push_ok(push_ok), .order_err(order_err), .overflow(overflow), .exp_count(exp_count)
  );

  always #50 clk = ~clk;

  typedef struct {
    int num;
    bit push_ok;
    bit order_err;
    bit overflow;
    int exp_count;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mq[$];
  bit          m_ov;
  int          n_chk = 0;
  int          n_err = 0;

  localparam logic [15:0] EMPTY_OBJ = 16'h0FFF;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int t, input int l, input int d);
    return {t[1:0], l[1:0], d[11:0]};
  endfunction

  // Compare the oldest scoreboard record and the whole visible queue against the model.
  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_val("num", 32'(num), 32'(e.num));
    check_val("push_ok", 32'(push_ok), 32'(e.push_ok));
    check_val("order_err", 32'(order_err), 32'(e.order_err));
    check_val("overflow", 32'(overflow), 32'(e.overflow));
    check_val("exp_count", 32'(exp_count), 32'(e.exp_count));
    check_val("empty", 32'(empty), 32'(e.num == 0));
    check_val("full", 32'(full), 32'(e.num == 16));
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      #1;
      check_val($sformatf("rd%0d", i), 32'(rd_obj), 32'((i < mq.size()) ? mq[i] : EMPTY_OBJ));
    end
  endtask

  // Drive one cycle, advance the model, queue the expectation, then check after the edge.
  task automatic step(input bit p, input logic [15:0] w, input bit pp,
                      input bit sc, input int st, input bit clr);
    exp_t e;
    int   ecnt;
    bit   ok;
    bit   oe;
    bit   sp_rej;
    @(negedge clk);
    push = p; wr_obj = w; pop = pp; scroll = sc; scroll_step = st[11:0]; clr_flags = clr;
    ecnt = 0;
    if (sc && st != 0) begin
      while (ecnt < mq.size() && int'(mq[ecnt][11:0]) <= st) ecnt++;
      for (int i = 0; i < ecnt; i++) void'(mq.pop_front());
      foreach (mq[i]) mq[i][11:0] = mq[i][11:0] - st[11:0];
    end
    if (pp && mq.size() > 0) void'(mq.pop_front());
    ok = 0; oe = 0; sp_rej = 0;
    if (p) begin
      if (mq.size() >= 16) sp_rej = 1;
      else if (mq.size() > 0 && w[11:0] < mq[mq.size()-1][11:0]) oe = 1;
      else begin
        mq.push_back(w);
        ok = 1;
      end
    end
    if (sp_rej) m_ov = 1;
    else if (clr) m_ov = 0;
    e.num = mq.size(); e.push_ok = ok; e.order_err = oe; e.overflow = m_ov; e.exp_count = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample();
    push = 0; pop = 0; scroll = 0; scroll_step = '0; clr_flags = 0; wr_obj = '0;
  endtask

  task automatic push1(input logic [15:0] w);
    step(1, w, 0, 0, 0, 0);
  endtask

  initial begin
    int tail;
    int wd;
    // Reset state
    m_ov = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_num", 32'(num), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_rd", 32'(rd_obj), 32'(EMPTY_OBJ));
    check_val("rst_flags", 32'({push_ok, order_err, overflow}), 32'd0);
    check_val("rst_exp", 32'(exp_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // T1: three ascending pushes
    push1(mk(1, 0, 80));
    push1(mk(2, 1, 90));
    push1(mk(3, 2, 100));

    // T2: scroll retires the front, then two more at the exact boundary
    step(0, '0, 0, 1, 85, 0);
    step(0, '0, 0, 1, 15, 0);

    // T3: fill, overflow, push+pop on full, clear racing a rejected push, clear alone
    for (int i = 0; i < 16; i++) push1(mk(i % 3, i % 4, 100 + 10 * i));
    push1(mk(1, 1, 1000));
    step(1, mk(2, 3, 1000), 1, 0, 0, 0);
    step(1, mk(2, 3, 1001), 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 1);

    // T4: retire all sixteen at once, then ordering
    step(0, '0, 0, 1, 4095, 0);
    push1(mk(0, 1, 100));
    push1(mk(0, 2, 50));
    push1(mk(1, 2, 100));

    // T5: steady-state push/pop pairs walking the pointers around the ring
    for (int i = 0; i < 40; i++) step(1, mk(i % 4, (i + 1) % 4, 105 + 5 * i), 1, 0, 0, 0);

    // T6: scroll + pop + push together; zero-step scroll is a no-op
    step(0, '0, 0, 1, 4095, 0);
    push1(mk(1, 0, 50));
    push1(mk(1, 1, 60));
    push1(mk(1, 2, 70));
    step(1, mk(2, 3, 30), 1, 1, 200, 0);
    step(1, mk(2, 0, 40), 0, 1, 0, 0);

    // Random mix
    for (int n = 0; n < 200; n++) begin
      tail = (mq.size() > 0) ? int'(mq[mq.size()-1][11:0]) : 0;
      wd = tail + int'($urandom_range(0, 60)) - 10;
      if (wd < 0) wd = 0;
      if (wd > 4095) wd = 4095;
      step($urandom_range(0, 3) != 0, mk($urandom_range(0, 3), $urandom_range(0, 3), wd),
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 40)), $urandom_range(0, 7) == 0);
    end

    // Reset dropped between edges while a scroll and push are pending
    @(negedge clk);
    push = 1; wr_obj = mk(1, 1, 4000); scroll = 1; scroll_step = 12'd5;
    #10;
    reset_n = 1'b0;
    #1;
    rd_index = '0;
    #1;
    check_val("midrst_num", 32'(num), 32'd0);
    check_val("midrst_empty", 32'(empty), 32'd1);
    check_val("midrst_rd", 32'(rd_obj), 32'(EMPTY_OBJ));
    check_val("midrst_flags", 32'({push_ok, order_err, overflow}), 32'd0);
    @(posedge clk);
    #1;
    check_val("inrst_num", 32'(num), 32'd0);
    check_val("inrst_exp", 32'(exp_count), 32'd0);
    @(negedge clk);
    push = 0; scroll = 0; scroll_step = '0; wr_obj = '0;
    reset_n = 1'b1;
    mq.delete();
    m_ov = 0;
    push1(mk(3, 3, 7));
    push1(mk(3, 0, 9));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
